// File: rtl/addr_reg_n.sv
// Byte-addressable N-lane register with full-word load, increment/decrement
// and a one-cycle wrap pulse when a count rolls over.
module addr_reg_n #(
   parameter int                   BYTES       = 2,
   parameter logic [8*BYTES-1:0]   RESET_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BYTES-1:0]     byteWriteEn,
   input  logic [7:0]           dataIn,
   input  logic                 wordLoadEn,
   input  logic [8*BYTES-1:0]   wordIn,
   input  logic                 incEn,
   input  logic                 decEn,
   input  logic [2:0]           byteSel,
   output logic [8*BYTES-1:0]   dataOut,
   output logic [7:0]           byteOut,
   output logic                 wrap
);

   localparam int W = 8 * BYTES;
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] data_q, data_d;
   logic         wrap_q, wrap_d;

   // Load beats byte writes, which beat counting; inc and dec together cancel.
   always_comb begin
      data_d = data_q;
      wrap_d = 1'b0;
      if (wordLoadEn) begin
         data_d = wordIn;
      end else if (|byteWriteEn) begin
         for (int i = 0; i < BYTES; i++) begin
            if (byteWriteEn[i]) begin
               data_d[8*i +: 8] = dataIn;
            end
         end
      end else if (incEn && !decEn) begin
         data_d = data_q + ONE;
         wrap_d = &data_q;
      end else if (decEn && !incEn) begin
         data_d = data_q - ONE;
         wrap_d = ~|data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= RESET_VALUE;
         wrap_q <= 1'b0;
      end else begin
         data_q <= data_d;
         wrap_q <= wrap_d;
      end
   end

   // Out-of-range lane selects fall back to lane 0.
   always_comb begin
      byteOut = data_q[7:0];
      for (int i = 0; i < BYTES; i++) begin
         if (byteSel == 3'(i)) begin
            byteOut = data_q[8*i +: 8];
         end
      end
   end

   assign dataOut = data_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_addr_reg_n.sv
// Directed bench for addr_reg_n: three instances (2, 3 and 4 lanes) sharing
// the narrow controls, each with its own wide load data and lane enables.
module tb_addr_reg_n;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  dataIn;
   logic        wordLoadEn;
   logic        incEn;
   logic        decEn;
   logic [2:0]  byteSel;

   logic [1:0]  byteWriteEn2;
   logic [15:0] wordIn2;
   logic [15:0] dataOut2;
   logic [7:0]  byteOut2;
   logic        wrap2;

   logic [2:0]  byteWriteEn3;
   logic [23:0] wordIn3;
   logic [23:0] dataOut3;
   logic [7:0]  byteOut3;
   logic        wrap3;

   logic [3:0]  byteWriteEn4;
   logic [31:0] wordIn4;
   logic [31:0] dataOut4;
   logic [7:0]  byteOut4;
   logic        wrap4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   addr_reg_n #(.BYTES(2)) dut2 (
      .clk(clk), .reset(reset), .byteWriteEn(byteWriteEn2), .dataIn(dataIn),
      .wordLoadEn(wordLoadEn), .wordIn(wordIn2), .incEn(incEn), .decEn(decEn),
      .byteSel(byteSel), .dataOut(dataOut2), .byteOut(byteOut2), .wrap(wrap2)
   );

   addr_reg_n #(.BYTES(3), .RESET_VALUE(24'h00ABCD)) dut3 (
      .clk(clk), .reset(reset), .byteWriteEn(byteWriteEn3), .dataIn(dataIn),
      .wordLoadEn(wordLoadEn), .wordIn(wordIn3), .incEn(incEn), .decEn(decEn),
      .byteSel(byteSel), .dataOut(dataOut3), .byteOut(byteOut3), .wrap(wrap3)
   );

   addr_reg_n #(.BYTES(4)) dut4 (
      .clk(clk), .reset(reset), .byteWriteEn(byteWriteEn4), .dataIn(dataIn),
      .wordLoadEn(wordLoadEn), .wordIn(wordIn4), .incEn(incEn), .decEn(decEn),
      .byteSel(byteSel), .dataOut(dataOut4), .byteOut(byteOut4), .wrap(wrap4)
   );

   // Advance one clock and settle just after the edge so outputs are stable.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Present a full-word load for one cycle on the given-width buses.
   task automatic loadWords(input logic [15:0] w2, input logic [23:0] w3,
                            input logic [31:0] w4);
      wordIn2 = w2;
      wordIn3 = w3;
      wordIn4 = w4;
      wordLoadEn = 1'b1;
      applyStimulus();
      wordLoadEn = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      dataIn = '0;
      wordLoadEn = 1'b0;
      incEn = 1'b0;
      decEn = 1'b0;
      byteSel = '0;
      byteWriteEn2 = '0;
      byteWriteEn3 = '0;
      byteWriteEn4 = '0;
      wordIn2 = '0;
      wordIn3 = '0;
      wordIn4 = '0;

      // Reset values.
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
      checkOutput("reset_data2", 32'(dataOut2), 32'h0000);
      checkOutput("reset_wrap2", 32'(wrap2), 32'h0);
      checkOutput("reset_data3", 32'(dataOut3), 32'h00ABCD);
      checkOutput("reset_data4", dataOut4, 32'h0);

      // Lane writes assemble 0x1234; byte readback per lane.
      byteWriteEn2 = 2'b01; dataIn = 8'h34;
      applyStimulus();
      checkOutput("lane0_write", 32'(dataOut2), 32'h0034);
      byteWriteEn2 = 2'b10; dataIn = 8'h12;
      applyStimulus();
      byteWriteEn2 = 2'b00;
      checkOutput("lane1_write", 32'(dataOut2), 32'h1234);
      byteSel = 3'd1; #1;
      checkOutput("byteout_sel1", 32'(byteOut2), 32'h12);
      byteSel = 3'd0; #1;
      checkOutput("byteout_sel0", 32'(byteOut2), 32'h34);
      byteSel = 3'd3; #1;
      checkOutput("byteout_sel3_oor", 32'(byteOut2), 32'h34);
      applyStimulus();
      checkOutput("hold", 32'(dataOut2), 32'h1234);

      // Increment with carry, then increment from all-ones.
      loadWords(16'h00FF, 24'h0, 32'h0);
      incEn = 1'b1;
      applyStimulus();
      incEn = 1'b0;
      checkOutput("inc_carry", 32'(dataOut2), 32'h0100);
      checkOutput("inc_carry_wrap", 32'(wrap2), 32'h0);
      loadWords(16'hFFFF, 24'h0, 32'h0);
      checkOutput("load_ones_wrap", 32'(wrap2), 32'h0);
      incEn = 1'b1;
      applyStimulus();
      incEn = 1'b0;
      checkOutput("inc_wrap_data", 32'(dataOut2), 32'h0000);
      checkOutput("inc_wrap_pulse", 32'(wrap2), 32'h1);
      applyStimulus();
      checkOutput("inc_wrap_cleared", 32'(wrap2), 32'h0);

      // Decrement with borrow, decrement from zero, inc+dec cancel.
      loadWords(16'h0100, 24'h0, 32'h0);
      decEn = 1'b1;
      applyStimulus();
      decEn = 1'b0;
      checkOutput("dec_borrow", 32'(dataOut2), 32'h00FF);
      checkOutput("dec_borrow_wrap", 32'(wrap2), 32'h0);
      loadWords(16'h0000, 24'h0, 32'h0);
      checkOutput("load_zero_wrap", 32'(wrap2), 32'h0);
      decEn = 1'b1;
      applyStimulus();
      checkOutput("dec_wrap_data", 32'(dataOut2), 32'hFFFF);
      checkOutput("dec_wrap_pulse", 32'(wrap2), 32'h1);
      incEn = 1'b1;
      applyStimulus();
      incEn = 1'b0; decEn = 1'b0;
      checkOutput("incdec_hold", 32'(dataOut2), 32'hFFFF);
      checkOutput("incdec_wrap", 32'(wrap2), 32'h0);

      // Priority: byte write over increment, load over everything.
      loadWords(16'h1234, 24'h0, 32'h0);
      byteWriteEn2 = 2'b01; dataIn = 8'hAA; incEn = 1'b1;
      applyStimulus();
      checkOutput("bytewr_over_inc", 32'(dataOut2), 32'h12AA);
      wordIn2 = 16'h5555; wordLoadEn = 1'b1;
      applyStimulus();
      wordLoadEn = 1'b0; byteWriteEn2 = 2'b00; incEn = 1'b0;
      checkOutput("load_over_all", 32'(dataOut2), 32'h5555);
      byteWriteEn2 = 2'b11; dataIn = 8'hFF;
      applyStimulus();
      byteWriteEn2 = 2'b00;
      checkOutput("bytewr_ones_data", 32'(dataOut2), 32'hFFFF);
      checkOutput("bytewr_ones_wrap", 32'(wrap2), 32'h0);

      // Three lanes: reset overrides simultaneous load and increment.
      loadWords(16'h0, 24'h123456, 32'h0);
      checkOutput("load3", 32'(dataOut3), 32'h123456);
      reset = 1'b1; incEn = 1'b1; wordLoadEn = 1'b1; wordIn3 = 24'hFFFFFF;
      applyStimulus();
      reset = 1'b0; incEn = 1'b0; wordLoadEn = 1'b0;
      checkOutput("reset_over_load3", 32'(dataOut3), 32'h00ABCD);
      checkOutput("reset_over_load3_wrap", 32'(wrap3), 32'h0);
      loadWords(16'h0, 24'hFFFFFF, 32'h0);
      reset = 1'b1; incEn = 1'b1;
      applyStimulus();
      reset = 1'b0; incEn = 1'b0;
      checkOutput("reset_over_inc3", 32'(dataOut3), 32'h00ABCD);
      checkOutput("reset_over_inc3_wrap", 32'(wrap3), 32'h0);
      byteSel = 3'd2; #1;
      checkOutput("byteout3_sel2", 32'(byteOut3), 32'h00);
      byteSel = 3'd1; #1;
      checkOutput("byteout3_sel1", 32'(byteOut3), 32'hAB);

      // Four lanes: carry and borrow across three lanes, out-of-range select.
      loadWords(16'h0, 24'h0, 32'h00FFFFFF);
      incEn = 1'b1;
      applyStimulus();
      incEn = 1'b0;
      checkOutput("inc4_carry", dataOut4, 32'h01000000);
      checkOutput("inc4_wrap", 32'(wrap4), 32'h0);
      decEn = 1'b1;
      applyStimulus();
      decEn = 1'b0;
      checkOutput("dec4_borrow", dataOut4, 32'h00FFFFFF);
      loadWords(16'h0, 24'h0, 32'h11223344);
      byteSel = 3'd5; #1;
      checkOutput("byteout4_sel5_oor", 32'(byteOut4), 32'h44);
      byteSel = 3'd3; #1;
      checkOutput("byteout4_sel3", 32'(byteOut4), 32'h11);
      byteSel = 3'd2; #1;
      checkOutput("byteout4_sel2", 32'(byteOut4), 32'h22);
      byteWriteEn4 = 4'b1010; dataIn = 8'hC3; decEn = 1'b1;
      applyStimulus();
      byteWriteEn4 = 4'b0000; decEn = 1'b0;
      checkOutput("bytewr4_mask", dataOut4, 32'hC322C344);
      loadWords(16'h0, 24'h0, 32'h0);
      decEn = 1'b1;
      applyStimulus();
      decEn = 1'b0;
      checkOutput("dec4_wrap_data", dataOut4, 32'hFFFFFFFF);
      checkOutput("dec4_wrap_pulse", 32'(wrap4), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/addr_reg_n.md
ADDR_REG_N -- requirements
Module: addr_reg_n

Interface
REQ-001 The block SHALL have parameter BYTES, default 2, giving the number of 8-bit byte lanes (legal 1..8).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, of width 8*BYTES, giving the register value after reset.
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 byteWriteEn  input  BYTES  per-lane write enable; bit i writes dataIn into byte i.
REQ-006 dataIn  input  8  byte write data.
REQ-007 wordLoadEn  input  1  full-width load enable.
REQ-008 wordIn  input  8*BYTES  full-width load data.
REQ-009 incEn  input  1  increment the whole word by 1.
REQ-010 decEn  input  1  decrement the whole word by 1.
REQ-011 byteSel  input  3  lane select for byteOut; values >= BYTES select lane 0.
REQ-012 dataOut  output  8*BYTES  registered value; byte i occupies bits [8i+7:8i].
REQ-013 byteOut  output  8  combinational byte i of dataOut, where i is the lane chosen by byteSel.
REQ-014 wrap  output  1  registered one-cycle pulse, asserted the cycle after an increment or decrement wraps the word.

Function
REQ-015 All state changes SHALL occur on the rising clk edge and be visible on dataOut in the following cycle (latency 1).
REQ-016 Update priority per cycle SHALL be: reset > wordLoadEn > any byteWriteEn bit > incEn/decEn > hold.
REQ-017 With wordLoadEn=1, dataOut SHALL take wordIn; byteWriteEn, incEn and decEn are ignored that cycle.
REQ-018 With wordLoadEn=0 and byteWriteEn!=0, every lane i with byteWriteEn[i]=1 SHALL take dataIn.
REQ-019 In the REQ-018 case, lanes with byteWriteEn[i]=0 SHALL hold, and incEn/decEn SHALL be ignored that cycle.
REQ-020 With no load and no byte write, incEn=1 and decEn=0 SHALL set dataOut to dataOut+1 modulo 2^(8*BYTES), with carry propagating across all lanes.
REQ-021 With no load and no byte write, decEn=1 and incEn=0 SHALL set dataOut to dataOut-1 modulo 2^(8*BYTES), with borrow propagating across all lanes.
REQ-022 incEn=1 together with decEn=1 SHALL leave dataOut unchanged and SHALL NOT assert wrap.
REQ-023 wrap SHALL be 1 in the cycle after an increment applied to all-ones (result 0) or a decrement applied to 0 (result all-ones).
REQ-024 wrap SHALL be 0 in every other cycle, including cycles after a load or byte write that produces 0 or all-ones.
REQ-025 byteOut SHALL follow dataOut and byteSel combinationally, with no additional register stage.

Reset
REQ-026 reset=1 at a rising edge SHALL set dataOut to RESET_VALUE and wrap to 0, overriding all other inputs in that cycle.
REQ-027 The reset of REQ-026 SHALL take effect even if an increment, decrement or load is requested in the same cycle.
REQ-028 Before the first reset, outputs are undefined; the block has no asynchronous behaviour.

Verification
REQ-029 BYTES=2 reset, then byteWriteEn=01 with dataIn=0x34, then byteWriteEn=10 with dataIn=0x12 -> dataOut=0x1234 and byteSel=1 gives byteOut=0x12.
REQ-030 BYTES=2: load 0x00FF, incEn for 1 cycle -> dataOut=0x0100, wrap=0; load 0xFFFF, incEn -> dataOut=0x0000, wrap=1 for exactly one cycle.
REQ-031 BYTES=2: load 0x0100, decEn -> 0x00FF; load 0x0000, decEn -> 0xFFFF with wrap=1; incEn=decEn=1 -> value held, wrap=0.
REQ-032 BYTES=2 priority: value 0x1234 with byteWriteEn=01, dataIn=0xAA and incEn=1 -> 0x12AA; the same plus wordLoadEn=1, wordIn=0x5555 -> 0x5555.
REQ-033 BYTES=3, RESET_VALUE=0x00ABCD: load 0x123456, then reset asserted together with incEn and wordLoadEn -> dataOut=0x00ABCD, wrap=0.
REQ-034 BYTES=4: load 0x00FFFFFF and increment -> 0x01000000; byteSel=5 (out of range) -> byteOut equals lane 0.
